hamming_dist_32: RTL and testbench
==================================

// Module: hamming_dist_32
// PURPOSE
//   Downstream consumer of the 32-bit XOR stage. Accepts two operand words over a
//   valid/ready handshake and latches their bitwise XOR (the difference vector). It
//   then counts the set bits of that vector over several cycles. It returns the
//   difference vector and the Hamming distance over a valid/ready output handshake.
//   Used as the mismatch/compare stage after bitwise XOR in the datapath.
// PARAMETERS
//   WIDTH           32  operand width in bits
//   BITS_PER_CYCLE  4   difference bits popcounted per COUNT cycle; must divide WIDTH
//   CNT_W (local)   $clog2(WIDTH+1) = 6, width of the count result
// PORTS
//   clk        in   1        single clock, all state updates on rising edge
//   rst_n      in   1        reset, synchronous, active-low
//   in_valid   in   1        operand pair valid
//   in_ready   out  1        block can accept an operand pair
//   input1     in   WIDTH    operand A
//   input2     in   WIDTH    operand B
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer accepts result
//   out_diff   out  WIDTH    latched input1 ^ input2
//   out_count  out  CNT_W    number of set bits in out_diff (0..WIDTH)
//   out_zero   out  1        1 when out_count == 0 (operands identical)
// BEHAVIOUR
//   - One clock domain. Reset is synchronous and active-low (rst_n sampled on clk).
//   - Reset (rst_n=0 at an edge): state=IDLE; out_valid=0, out_diff=0, out_count=0,
//     out_zero=0; internal shift register and chunk counter cleared.
//     in_ready is forced 0 while rst_n=0.
//   - Reset mid-COUNT or mid-DONE: the operation is discarded with no output beat.
//   - FSM states: IDLE -> COUNT -> DONE -> IDLE.
//   - IDLE: in_ready=1. On an edge with in_valid=1:
//     latch sh = input1^input2, out_diff = the same value, acc=0, chunk=0; go to COUNT.
//   - COUNT: in_ready=0, out_valid=0. Each edge:
//     acc += popcount(sh[BITS_PER_CYCLE-1:0]); sh >>= BITS_PER_CYCLE; chunk++.
//     Go to DONE when chunk was WIDTH/BITS_PER_CYCLE-1 (the last chunk).
//     On that edge, load out_count = final acc and set out_zero accordingly.
//   - Latency: out_valid rises exactly WIDTH/BITS_PER_CYCLE (=8) edges after the
//     accepting edge.
//   - DONE: out_valid=1; out_diff, out_count and out_zero are held stable until an
//     edge with out_ready=1. On that edge out_valid drops to 0 and the FSM returns
//     to IDLE.
//   - in_ready is 1 only in IDLE, so at most one operation is in flight.
//     Throughput is 1 result per (WIDTH/BITS_PER_CYCLE + 2) cycles with
//     out_ready held 1.
//   - Inputs are ignored outside IDLE. in_valid is not required to stay high.
//   - Arithmetic: acc is CNT_W bits wide and cannot overflow (max value WIDTH).
//     Per-chunk popcount is unsigned.
// CONFIGURATION
//   HAMMING_EARLY_EXIT_EN
//   - Defined: in COUNT, also go to DONE on any edge where the post-shift sh == 0.
//     Latency becomes 1..8 edges: the index of the highest set chunk + 1, minimum 1.
//     Results are identical to the non-defined build.
//   - Undefined: fixed latency of WIDTH/BITS_PER_CYCLE edges.
//   - Handshake rules are unchanged in both builds.
// TESTING
//   1 input1=FFFF0000, input2=0000FFFF ->
//     out_diff=FFFFFFFF, out_count=32, out_zero=0; out_valid 8 edges after accept.
//   2 input1=input2=A5A5A5A5 -> out_diff=0, out_count=0, out_zero=1.
//     Latency is 8 edges (macro off) or 1 edge (macro on).
//   3 input1=80000000, input2=0 -> out_count=1, latency 8 in both builds.
//     input1=00000001, input2=0 -> out_count=1, latency 8 (off) or 1 (on).
//   4 Result ready, out_ready=0 for 5 cycles -> out_valid, out_diff and out_count
//     are stable, in_ready=0, and a new in_valid is ignored.
//     Then out_ready=1 -> IDLE on the next edge.
//   5 rst_n=0 for one edge on the 3rd COUNT cycle -> out_valid stays 0 and all
//     outputs read 0. in_ready=1 after release; a new accept produces a correct
//     result.
//   6 Back-to-back: 3 random pairs with out_ready tied 1 -> each out_count equals
//     popcount(a^b), and accepts are spaced 10 cycles apart.

Source files
------------

// File: rtl/hamming_dist_32.sv
// hamming_dist_32
//   Mismatch/compare stage that follows the bitwise XOR in the datapath.
//   It accepts an operand pair, latches the difference vector (input1 ^ input2),
//   and popcounts that vector BITS_PER_CYCLE bits per cycle. It then presents the
//   vector, the Hamming distance and a zero flag on a valid/ready output.
//   Only one operation is in flight at a time: in_ready is high only in IDLE.
//
//   Optional build macro: HAMMING_EARLY_EXIT_EN
//     When defined, counting stops as soon as the remaining shifted vector is
//     zero. Results are the same; only the latency changes (1..WIDTH/BITS_PER_CYCLE).
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  block can accept an operand pair (IDLE and not in reset)
//   input1     in   operand A
//   input2     in   operand B
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   out_diff   out  latched input1 ^ input2
//   out_count  out  number of set bits in out_diff
//   out_zero   out  1 when out_count == 0
module hamming_dist_32 #(
    parameter  int WIDTH          = 32,
    parameter  int BITS_PER_CYCLE = 4,
    localparam int CNT_W          = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero
);

    localparam int NCHUNK = WIDTH / BITS_PER_CYCLE;
    localparam int CHK_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [CHK_W-1:0]   chunk_q, chunk_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               zero_q, zero_d;

    logic [CNT_W-1:0]   part;
    logic [CNT_W-1:0]   acc_sum;
    logic [WIDTH-1:0]   sh_shift;
    logic               last;

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        chunk_d  = chunk_q;
        diff_d   = diff_q;
        count_d  = count_q;
        zero_d   = zero_q;
        last     = 1'b0;

        // popcount of the low chunk of the shift register
        part = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            part = part + CNT_W'(sh_q[i]);
        end
        acc_sum  = acc_q + part;
        sh_shift = sh_q >> BITS_PER_CYCLE;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_d    = input1 ^ input2;
                    diff_d  = input1 ^ input2;
                    acc_d   = '0;
                    chunk_d = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                acc_d   = acc_sum;
                sh_d    = sh_shift;
                chunk_d = chunk_q + CHK_W'(1);
                last    = (chunk_q == CHK_W'(NCHUNK - 1));
`ifdef HAMMING_EARLY_EXIT_EN
                // nothing left to count: acc_sum is already final
                last    = last | (sh_shift == '0);
`endif
                if (last) begin
                    count_d = acc_sum;
                    zero_d  = (acc_sum == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            chunk_q <= '0;
            diff_q  <= '0;
            count_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            chunk_q <= chunk_d;
            diff_q  <= diff_d;
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_diff  = diff_q;
    assign out_count = count_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_hamming_dist_32.sv
module tb_hamming_dist_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_diff;
    logic [5:0]  out_count;
    logic        out_zero;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    hamming_dist_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input1    (input1),
        .input2    (input2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .out_count (out_count),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: latency from accept to out_valid
    function automatic int exp_lat(input logic [31:0] d);
`ifdef HAMMING_EARLY_EXIT_EN
        int hi;
        hi = -1;
        for (int i = 0; i < 32; i++) if (d[i]) hi = i;
        return (hi < 0) ? 1 : hi / 4 + 1;
`else
        return 8;
`endif
    endfunction

    // Drive one operand pair from IDLE; return edges until out_valid (40 = timeout)
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        input1 = a; input2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; input1 = '0; input2 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_diff !== 32'h0 ||
            out_count !== 6'd0 || out_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b diff=%h cnt=%0d zero=%b, required 0/0/0/0/0",
                     in_ready, out_valid, out_diff, out_count, out_zero);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [31:0] d;
        d = a ^ b;
        do_op(a, b, lat);
        n_chk++;
        if (lat !== exp_lat(d)) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat(d));
        end
        n_chk++;
        if (out_diff !== d || out_count !== 6'($countones(d)) || out_zero !== (d == 0)) begin
            n_fail++;
            $display("FAIL %s_result: diff=%h cnt=%0d zero=%b, required %h %0d %b",
                     name, out_diff, out_count, out_zero, d, $countones(d), d == 0);
        end
        release_out();
    endtask

    task automatic test_vectors();
        check_op("all_diff", 32'hFFFF0000, 32'h0000FFFF);
        check_op("identical", 32'hA5A5A5A5, 32'hA5A5A5A5);
        check_op("msb_only", 32'h80000000, 32'h0);
        check_op("lsb_only", 32'h00000001, 32'h0);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            if (i == 4) b = a ^ 32'h00000F00;
            check_op("random", a, b);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] d;
        d = 32'h12345678 ^ 32'h0F0F0F0F;
        do_op(32'h12345678, 32'h0F0F0F0F, lat);
        n_chk++;
        if (lat !== exp_lat(d)) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d, required %0d", lat, exp_lat(d));
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; input1 = $urandom; input2 = $urandom;
            @(posedge clk); #1;
            n_chk++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_diff !== d ||
                out_count !== 6'($countones(d))) begin
                n_fail++;
                $display("FAIL bp_hold: vld=%b rdy=%b diff=%h cnt=%0d, required 1 0 %h %0d",
                         out_valid, in_ready, out_diff, out_count, d, $countones(d));
            end
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        input1 = 32'hDEADBEEF; input2 = 32'h0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_diff !== 32'h0 ||
            out_count !== 6'd0 || out_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: vld=%b rdy=%b diff=%h cnt=%0d zero=%b, required all 0",
                     out_valid, in_ready, out_diff, out_count, out_zero);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_ready: got %b, required 1", in_ready);
        end
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_chk++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midreset_no_beat: out_valid seen %0d cycles, required 0", seen);
        end
        check_op("after_reset", 32'hCAFEF00D, 32'h13572468);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a[3], b[3];
        int acc_cyc[3];
        int got_cnt[$];
        logic [31:0] got_diff[$];
        int wait_n;
        for (int k = 0; k < 3; k++) begin a[k] = $urandom; b[k] = $urandom; end
        @(negedge clk); out_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    wait_n = 0;
                    @(negedge clk);
                    while (!in_ready && wait_n < 40) begin @(negedge clk); wait_n++; end
                    input1 = a[k]; input2 = b[k]; in_valid = 1'b1;
                    @(posedge clk); #1;
                    acc_cyc[k] = cyc;
                end
                @(negedge clk); in_valid = 1'b0;
            end
            begin
                for (int t = 0; t < 60 && got_cnt.size() < 3; t++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        got_cnt.push_back(int'(out_count));
                        got_diff.push_back(out_diff);
                    end
                end
            end
        join
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (k >= got_cnt.size()) begin
                n_fail++;
                $display("FAIL b2b_result%0d: missing, required count %0d", k, $countones(a[k] ^ b[k]));
            end else if (got_cnt[k] != $countones(a[k] ^ b[k]) || got_diff[k] !== (a[k] ^ b[k])) begin
                n_fail++;
                $display("FAIL b2b_result%0d: cnt=%0d diff=%h, required %0d %h",
                         k, got_cnt[k], got_diff[k], $countones(a[k] ^ b[k]), a[k] ^ b[k]);
            end
        end
        for (int k = 1; k < 3; k++) begin
            n_chk++;
            if (acc_cyc[k] - acc_cyc[k-1] != exp_lat(a[k-1] ^ b[k-1]) + 2) begin
                n_fail++;
                $display("FAIL b2b_spacing%0d: got %0d, required %0d",
                         k, acc_cyc[k] - acc_cyc[k-1], exp_lat(a[k-1] ^ b[k-1]) + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
